// File: rtl/uart_receiver.sv
// UART receiver: oversampled start detection, LSB-first data, even parity
// (parity bit = XOR of data bits), single stop bit. Results are registered
// together with a one-clk rx_done strobe.
// Optional build macro UART_RX_SYNC_EN: adds a 2-flop input synchronizer
// (reset to line-idle 1) in front of the receiver, costing 2 clk of latency.
module uart_receiver #(
   parameter int DATA_SIZE  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 sample_tick,
   input  logic                 serial_data_in,
   output logic [DATA_SIZE-1:0] data_out,
   output logic                 rx_done,
   output logic                 parity_error,
   output logic                 frame_error
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_SIZE + 1);
   localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_SIZE - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                 state_q;
   logic [TW-1:0]          tick_cnt_q;
   logic [BW-1:0]          bit_cnt_q;
   logic [DATA_SIZE-1:0]   shift_q;
   logic                   par_flag_q;
   logic [DATA_SIZE-1:0]   data_q;
   logic                   done_q;
   logic                   par_err_q;
   logic                   frm_err_q;
   logic                   rx_s;

`ifdef UART_RX_SYNC_EN
   logic [1:0]             sync_q;

   // Two-flop synchronizer; resets to the idle line level so no false start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= 2'b11;
      else          sync_q <= {sync_q[0], serial_data_in};
   end

   assign rx_s = sync_q[1];
`else
   assign rx_s = serial_data_in;
`endif

   // Receive FSM with counters, shift register and registered frame results.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_flag_q <= 1'b0;
         data_q     <= '0;
         done_q     <= 1'b0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
      end else begin
         // rx_done is a single-clk strobe independent of the tick rate
         done_q <= 1'b0;
         if (sample_tick) begin
            case (state_q)
               IDLE: begin
                  if (!rx_s) begin
                     tick_cnt_q <= '0;
                     state_q    <= START;
                  end
               end
               START: begin
                  if (tick_cnt_q == TICK_MID) begin
                     tick_cnt_q <= '0;
                     bit_cnt_q  <= '0;
                     // a high line at mid start bit is treated as a glitch
                     state_q    <= rx_s ? IDLE : DATA;
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 1'b1;
                  end
               end
               DATA: begin
                  if (tick_cnt_q == TICK_END) begin
                     tick_cnt_q <= '0;
                     shift_q    <= {rx_s, shift_q[DATA_SIZE-1:1]};
                     bit_cnt_q  <= bit_cnt_q + 1'b1;
                     if (bit_cnt_q == BIT_LAST) state_q <= PARITY;
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 1'b1;
                  end
               end
               PARITY: begin
                  if (tick_cnt_q == TICK_END) begin
                     tick_cnt_q <= '0;
                     par_flag_q <= rx_s ^ (^shift_q);
                     state_q    <= STOP;
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 1'b1;
                  end
               end
               STOP: begin
                  if (tick_cnt_q == TICK_END) begin
                     tick_cnt_q <= '0;
                     // data is delivered even when an error flag is raised
                     data_q     <= shift_q;
                     par_err_q  <= par_flag_q;
                     frm_err_q  <= ~rx_s;
                     done_q     <= 1'b1;
                     state_q    <= IDLE;
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign data_out     = data_q;
   assign rx_done      = done_q;
   assign parity_error = par_err_q;
   assign frame_error  = frm_err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: table of single frames plus hand-written
// sequences for false start, mid-frame reset, back-to-back frames and break.
module tb_uart_receiver;

   localparam int DS = 8;
   localparam int OS = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          sample_tick;
   logic          serial;
   logic [DS-1:0] data_out;
   logic          rx_done;
   logic          parity_error;
   logic          frame_error;

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      logic [DS-1:0] data;
      logic          pe;
      logic          fe;
   } rec_t;

   rec_t rq[$];
   int   long_pulses = 0;
   logic done_prev   = 1'b0;

   typedef struct {
      logic [DS-1:0] data;
      bit            par_ok;
      bit            stop;
      bit            exp_pe;
      bit            exp_fe;
   } vec_t;

   vec_t vecs[6];

   uart_receiver #(.DATA_SIZE(DS), .OVERSAMPLE(OS)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .sample_tick    (sample_tick),
      .serial_data_in (serial),
      .data_out       (data_out),
      .rx_done        (rx_done),
      .parity_error   (parity_error),
      .frame_error    (frame_error)
   );

   always #5 clk = ~clk;

   // tick on every other rising edge
   initial begin
      sample_tick = 1'b0;
      forever begin
         @(negedge clk);
         sample_tick = ~sample_tick;
      end
   end

   // record every rx_done pulse and flag any pulse longer than one clk
   always @(negedge clk) begin
      if (rx_done) rq.push_back('{data_out, parity_error, frame_error});
      if (rx_done && done_prev) long_pulses++;
      done_prev = rx_done;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic hold_line(input logic b, input int nticks);
      serial = b;
      for (int i = 0; i < nticks; i++) begin
         do @(posedge clk); while (sample_tick !== 1'b1);
      end
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [DS-1:0] d, input bit par_ok, input bit stop);
      hold_line(1'b0, OS);
      for (int i = 0; i < DS; i++) hold_line(d[i], OS);
      hold_line((^d) ^ ~par_ok, OS);
      hold_line(stop, OS);
   endtask

   initial begin
      vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0};

      reset_n = 1'b0;
      serial  = 1'b1;
      repeat (4) @(negedge clk);
      check("reset data_out", 32'(data_out), 32'h0);
      check("reset rx_done", 32'(rx_done), 32'h0);
      check("reset parity_error", 32'(parity_error), 32'h0);
      check("reset frame_error", 32'(frame_error), 32'h0);
      reset_n = 1'b1;
      hold_line(1'b1, 8);

      // table of single frames
      for (int v = 0; v < 6; v++) begin
         rq.delete();
         send_frame(vecs[v].data, vecs[v].par_ok, vecs[v].stop);
         hold_line(1'b1, 24);
         check($sformatf("vec%0d pulses", v), 32'(rq.size()), 32'd1);
         check($sformatf("vec%0d data", v), 32'(data_out), 32'(vecs[v].data));
         check($sformatf("vec%0d parity_error", v), 32'(parity_error), 32'(vecs[v].exp_pe));
         check($sformatf("vec%0d frame_error", v), 32'(frame_error), 32'(vecs[v].exp_fe));
      end

      // short low glitch is a false start, then a normal frame
      rq.delete();
      hold_line(1'b0, 4);
      hold_line(1'b1, 24);
      check("false start pulses", 32'(rq.size()), 32'd0);
      send_frame(8'h5A, 1'b1, 1'b1);
      hold_line(1'b1, 24);
      check("after false start pulses", 32'(rq.size()), 32'd1);
      check("after false start data", 32'(data_out), 32'h5A);
      check("after false start errors", 32'({parity_error, frame_error}), 32'h0);

      // reset in the middle of data bit 3 of 0xFF
      rq.delete();
      hold_line(1'b0, OS);
      for (int i = 0; i < 3; i++) hold_line(1'b1, OS);
      hold_line(1'b1, 8);
      reset_n = 1'b0;
      #1;
      check("midreset data_out", 32'(data_out), 32'h0);
      check("midreset rx_done", 32'(rx_done), 32'h0);
      check("midreset errors", 32'({parity_error, frame_error}), 32'h0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      hold_line(1'b1, 24);
      check("midreset pulses", 32'(rq.size()), 32'd0);
      send_frame(8'h81, 1'b1, 1'b1);
      hold_line(1'b1, 24);
      check("after reset pulses", 32'(rq.size()), 32'd1);
      check("after reset data", 32'(data_out), 32'h81);

      // back-to-back frames (0x34 has odd weight, parity bit 1)
      rq.delete();
      send_frame(8'h12, 1'b1, 1'b1);
      send_frame(8'h34, 1'b1, 1'b1);
      hold_line(1'b1, 24);
      check("b2b pulses", 32'(rq.size()), 32'd2);
      if (rq.size() == 2) begin
         check("b2b first data", 32'(rq[0].data), 32'h12);
         check("b2b second data", 32'(rq[1].data), 32'h34);
         check("b2b first errors", 32'({rq[0].pe, rq[0].fe}), 32'h0);
         check("b2b second errors", 32'({rq[1].pe, rq[1].fe}), 32'h0);
      end

      // break: stop bit low and line held low for 180 ticks from stop start
      rq.delete();
      hold_line(1'b0, OS);
      for (int i = 0; i < DS; i++) hold_line(((8'hC3 >> i) & 8'h01) != 0, OS);
      hold_line(1'b0, OS);
      hold_line(1'b0, 180);
      hold_line(1'b1, 40);
      check("break pulses", 32'(rq.size()), 32'd2);
      if (rq.size() == 2) begin
         check("break first data", 32'(rq[0].data), 32'hC3);
         check("break first flags", 32'({rq[0].pe, rq[0].fe}), 32'h1);
         check("break second data", 32'(rq[1].data), 32'h00);
         check("break second flags", 32'({rq[1].pe, rq[1].fe}), 32'h1);
      end
      send_frame(8'h5A, 1'b1, 1'b1);
      hold_line(1'b1, 24);
      check("after break data", 32'(data_out), 32'h5A);
      check("after break errors", 32'({parity_error, frame_error}), 32'h0);

      check("rx_done single-clk pulses", 32'(long_pulses), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
